// File: rtl/pio_bcd_seg_driver_if.sv
// Display-side bundle between the PIO BCD/7-segment driver and its consumer.
// The slave modport is the driver; the master modport supplies value_in and observes results.
interface pio_bcd_seg_driver_if #(
  parameter int IN_WIDTH = 12,
  parameter int DIGITS   = 4
);
  logic [IN_WIDTH-1:0] value_in;
  logic [4*DIGITS-1:0] bcd_out;
  logic [6:0]          hex0;
  logic [6:0]          hex1;
  logic [6:0]          hex2;
  logic [6:0]          hex3;
  logic                busy;
  logic                done;

  modport master (
    output value_in,
    input  bcd_out, hex0, hex1, hex2, hex3, busy, done
  );

  modport slave (
    input  value_in,
    output bcd_out, hex0, hex1, hex2, hex3, busy, done
  );
endinterface

// File: rtl/pio_bcd_seg_driver.sv
// PIO binary -> BCD (sequential double-dabble) -> 7-seg; done IN_WIDTH+1 edges after capture.
// No backpressure: input changes mid-conversion are picked up afterwards; PIO_BCD_LEADING_ZERO_BLANK_EN blanks leading zeros.
module pio_bcd_seg_driver #(
  parameter int IN_WIDTH       = 12,
  parameter int DIGITS         = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_bcd_seg_driver_if.slave   bus
);

  localparam int         BCD_W     = 4 * DIGITS;
  localparam int         CNT_W     = $clog2(IN_WIDTH + 1);
  localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] shift_bin;
  logic [IN_WIDTH-1:0] last_val;
  logic [BCD_W-1:0]    bcd_acc;
  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_r;
  logic [CNT_W-1:0]    iter_cnt;
  logic                force_conv;
  logic                busy_r;
  logic                done_r;
  logic [DIGITS-1:0]   blank_mask;
  logic [6:0]          seg_r   [DIGITS];
  logic [6:0]          seg_nxt [DIGITS];

  // Table is active-low gfedcba; unreachable nibbles decode as blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return SEG_ACTIVE_LOW ? s : ~s;
  endfunction

  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
    end
  end

`ifdef PIO_BCD_LEADING_ZERO_BLANK_EN
  // Walk down from the top digit while every digit seen so far is zero; digit 0 always shows.
  always_comb begin
    logic lead;
    lead       = 1'b1;
    blank_mask = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead          = lead && (bcd_acc[4*i +: 4] == 4'd0);
      blank_mask[i] = lead;
    end
  end
`else
  assign blank_mask = '0;
`endif

  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      seg_nxt[i] = blank_mask[i] ? SEG_BLANK : seg_decode(bcd_acc[4*i +: 4]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift_bin  <= '0;
      last_val   <= '0;
      bcd_acc    <= '0;
      bcd_r      <= '0;
      iter_cnt   <= '0;
      force_conv <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      for (int i = 0; i < DIGITS; i++)
        seg_r[i] <= SEG_BLANK;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if ((bus.value_in != last_val) || force_conv) begin
            shift_bin  <= bus.value_in;
            last_val   <= bus.value_in;
            bcd_acc    <= '0;
            iter_cnt   <= '0;
            force_conv <= 1'b0;
            busy_r     <= 1'b1;
            state      <= CONV;
          end
        end
        CONV: begin
          bcd_acc   <= {bcd_adj[BCD_W-2:0], shift_bin[IN_WIDTH-1]};
          shift_bin <= {shift_bin[IN_WIDTH-2:0], 1'b0};
          iter_cnt  <= iter_cnt + CNT_W'(1);
          if (iter_cnt == CNT_W'(IN_WIDTH - 1))
            state <= LOAD;
        end
        LOAD: begin
          bcd_r  <= bcd_acc;
          seg_r  <= seg_nxt;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bcd_out = bcd_r;
  assign bus.hex0    = seg_r[0];
  assign bus.hex1    = seg_r[1];
  assign bus.hex2    = seg_r[2];
  assign bus.hex3    = seg_r[3];
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_pio_bcd_seg_driver.sv
// Directed bench for pio_bcd_seg_driver: latency, digit decode, retrigger rules and reset mid-conversion.
module tb_pio_bcd_seg_driver;
  localparam int IN_WIDTH = 12;
  localparam int DIGITS   = 4;
`ifdef PIO_BCD_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  bit   clk = 1'b0;
  logic reset_n;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   done_cnt     = 0;

  pio_bcd_seg_driver_if #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) bus ();

  pio_bcd_seg_driver #(
    .IN_WIDTH(IN_WIDTH),
    .DIGITS(DIGITS),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until done is seen (bounded); n = ticks taken, busy_n = ticks with busy high.
  task automatic wait_done(input string tag, output int n, output int busy_n);
    bit seen;
    n      = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_hex(input string tag, input logic [6:0] h3, input logic [6:0] h2,
                           input logic [6:0] h1, input logic [6:0] h0);
    check({tag, "_hex3"}, 32'(bus.hex3), 32'(h3));
    check({tag, "_hex2"}, 32'(bus.hex2), 32'(h2));
    check({tag, "_hex1"}, 32'(bus.hex1), 32'(h1));
    check({tag, "_hex0"}, 32'(bus.hex0), 32'(h0));
  endtask

  initial begin
    int n, busy_n, snap;
    logic [6:0] lz;
    lz = LZB ? 7'h7F : 7'h40;

    // 1: reset, then forced conversion of 0
    reset_n      = 1'b0;
    bus.value_in = '0;
    repeat (3) tick();
    check("rst_bcd",  32'(bus.bcd_out), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check_hex("rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    reset_n = 1'b1;
    wait_done("t1", n, busy_n);
    check("t1_latency", 32'(n), 32'd14);
    check("t1_bcd", 32'(bus.bcd_out), 32'h0000);
    check_hex("t1", lz, lz, lz, 7'h40);
    tick();

    // 2: full-scale value
    snap = done_cnt;
    bus.value_in = 12'd4095;
    wait_done("t2", n, busy_n);
    check("t2_latency", 32'(n), 32'd14);
    check("t2_busy_cycles", 32'(busy_n), 32'd13);
    check("t2_bcd", 32'(bus.bcd_out), 32'h4095);
    check_hex("t2", 7'h19, 7'h40, 7'h10, 7'h12);
    tick();
    check("t2_done_pulse_len", 32'(bus.done), 32'd0);
    check("t2_busy_after", 32'(bus.busy), 32'd0);
    check("t2_done_count", 32'(done_cnt - snap), 32'd1);

    // extra decode coverage: 3867 and 1234
    bus.value_in = 12'd3867;
    wait_done("t2b", n, busy_n);
    check("t2b_bcd", 32'(bus.bcd_out), 32'h3867);
    check_hex("t2b", 7'h30, 7'h00, 7'h02, 7'h78);
    tick();
    bus.value_in = 12'd1234;
    wait_done("t2c", n, busy_n);
    check("t2c_bcd", 32'(bus.bcd_out), 32'h1234);
    check_hex("t2c", 7'h79, 7'h24, 7'h30, 7'h19);
    tick();

    // 3: change mid-conversion is picked up afterwards
    snap = done_cnt;
    bus.value_in = 12'd123;
    repeat (5) tick();
    check("t3_busy_mid", 32'(bus.busy), 32'd1);
    bus.value_in = 12'd456;
    wait_done("t3a", n, busy_n);
    check("t3a_remaining", 32'(n), 32'd9);
    check("t3a_bcd", 32'(bus.bcd_out), 32'h0123);
    wait_done("t3b", n, busy_n);
    check("t3b_latency", 32'(n), 32'd14);
    check("t3b_bcd", 32'(bus.bcd_out), 32'h0456);
    tick();
    check("t3_done_count", 32'(done_cnt - snap), 32'd2);

    // 4: reset during a conversion
    bus.value_in = 12'd999;
    repeat (6) tick();
    snap = done_cnt;
    reset_n = 1'b0;
    tick();
    check("t4_busy", 32'(bus.busy), 32'd0);
    check("t4_done", 32'(bus.done), 32'd0);
    check("t4_bcd",  32'(bus.bcd_out), 32'h0);
    check_hex("t4", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    reset_n = 1'b1;
    wait_done("t4r", n, busy_n);
    check("t4r_latency", 32'(n), 32'd14);
    check("t4r_bcd", 32'(bus.bcd_out), 32'h0999);
    tick();
    check("t4_done_count", 32'(done_cnt - snap), 32'd1);

    // 5: stable input never retriggers
    bus.value_in = 12'd250;
    wait_done("t5", n, busy_n);
    tick();
    snap = done_cnt;
    repeat (100) tick();
    check("t5_no_retrigger", 32'(done_cnt - snap), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_bcd", 32'(bus.bcd_out), 32'h0250);
    check_hex("t5", lz, 7'h24, 7'h12, 7'h40);

`ifdef PIO_BCD_LEADING_ZERO_BLANK_EN
    // 6: leading-zero blanking
    bus.value_in = 12'd7;
    wait_done("t6a", n, busy_n);
    check("t6a_bcd", 32'(bus.bcd_out), 32'h0007);
    check_hex("t6a", 7'h7F, 7'h7F, 7'h7F, 7'h78);
    tick();
    bus.value_in = 12'd0;
    wait_done("t6b", n, busy_n);
    check("t6b_bcd", 32'(bus.bcd_out), 32'h0000);
    check_hex("t6b", 7'h7F, 7'h7F, 7'h7F, 7'h40);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pio_bcd_seg_driver.md
Name: pio_bcd_seg_driver

Overview:
- Downstream consumer of the 12-bit Avalon PIO output port.
- Converts the unsigned binary value on the port to 4 BCD digits using a sequential double-dabble, one shift per clock.
- Drives four 7-segment displays (HEX0..HEX3) from registered outputs.
- Reconverts only when the input changes; a busy/done pair lets software or verification track completion.

Parameters:
- IN_WIDTH, 12: binary input width; also the number of conversion iterations.
- DIGITS, 4: number of BCD digits and displays. Must satisfy 10^DIGITS > 2^IN_WIDTH - 1.
- SEG_ACTIVE_LOW, 1: 1 inverts segment outputs (segment lit = 0); 0 gives active-high segments.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- value_in  in  IN_WIDTH  binary value from PIO out_port
- bcd_out  out  4*DIGITS  registered BCD result; digit 0 in [3:0]
- hex0  out  7  segments for digit 0 (ones); bit0=a .. bit6=g
- hex1  out  7  digit 1 (tens)
- hex2  out  7  digit 2 (hundreds)
- hex3  out  7  digit 3 (thousands)
- busy  out  1  high while a conversion is in progress (CONV or LOAD)
- done  out  1  one-cycle pulse, coincident with the bcd_out/hex update

Behaviour:
- Reset (reset_n=0 at a rising edge) applies regardless of state:
  - bcd_out=0, busy=0, done=0.
  - All hex outputs blank: all segments off, i.e. 7'h7F when active-low.
  - state=IDLE, last_val=0, force flag set.
- FSM states: IDLE, CONV, LOAD.
- IDLE:
  - Start a conversion when (value_in != last_val) or force=1.
  - On start: capture value_in into shift_bin and last_val, clear the BCD accumulator and iteration counter, clear force, go to CONV.
  - busy goes high the cycle after the capturing edge.
- CONV, one iteration per edge:
  - Any BCD nibble >= 5 gets +3 (4-bit add, no carry between nibbles).
  - Then {bcd, shift_bin} shifts left by 1.
  - After IN_WIDTH iterations go to LOAD.
- LOAD, one edge:
  - Register the accumulator into bcd_out.
  - Decode each digit into its hex output.
  - Pulse done=1 for exactly one cycle; go to IDLE. busy=0 in the following cycle.
- Latency: with the capturing edge as E0, iterations occur on E1..E12 and outputs update on E13. Total is IN_WIDTH+1 edges after capture, so 13 cycles by default.
- value_in changes during CONV/LOAD are ignored. IDLE compares against last_val on the next cycle, so the newest value is picked up and no separate queue exists.
- A stable input never retriggers: exactly one done per distinct captured value.
- Outputs hold their last value between conversions; no intermediate digits are ever visible.
- Segment decode, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - Nibbles 10-15 are unreachable; decode them as blank.
- When SEG_ACTIVE_LOW=0, outputs are the bitwise inverse of the table.
- Max input 4095 yields 0x4095; no overflow is possible with the default parameters.

Optional Feature:
- Macro: PIO_BCD_LEADING_ZERO_BLANK_EN.
- When defined: at LOAD, any zero digit more significant than the highest nonzero digit is blanked (all segments off). Digit 0 is never blanked, so value 0 shows a single "0". bcd_out is unaffected.
- When undefined: all DIGITS displays always show their digit, including leading zeros.

Test Plan:
1. Reset held 3 cycles with value_in=0, then released → forced conversion; done pulse on the 14th edge after release. bcd_out=16'h0000, hex3..hex0=7'h40 (macro off).
2. value_in=12'd4095 from IDLE → busy for 13 cycles, then a single done. bcd_out=16'h4095; hex3=7'h19, hex2=7'h40, hex1=7'h10, hex0=7'h12.
3. value_in=123, then 456 applied 5 cycles into the conversion → first done gives bcd_out=16'h0123. A second conversion starts 1 cycle later; second done gives 16'h0456. Exactly 2 done pulses total.
4. reset_n=0 asserted 6 cycles into a conversion of 999 → next cycle: busy=0, bcd_out=0, hex all 7'h7F, no done. After release, value 999 is forced through → bcd_out=16'h0999.
5. value_in held at 250 for 100 cycles after its conversion → no further done pulses; outputs stay 16'h0250.
6. Macro defined, value_in=7 → hex3=hex2=hex1=7'h7F, hex0=7'h78. Then value_in=0 → hex0=7'h40, others 7'h7F.
